// File: rtl/dispense_ctrl_pkg.sv
// rtl/dispense_ctrl_pkg.sv - state encoding, coin encodings and coin values for dispense_ctrl
package dispense_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TICKET = 2'd1,
      CHANGE = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      COIN_1  = 2'b00,
      COIN_5  = 2'b01,
      COIN_10 = 2'b10,
      COIN_50 = 2'b11
   } coin_t;

   localparam logic [7:0] VAL_1  = 8'd1;
   localparam logic [7:0] VAL_5  = 8'd5;
   localparam logic [7:0] VAL_10 = 8'd10;
   localparam logic [7:0] VAL_50 = 8'd50;

   function automatic logic [7:0] coin_value(input coin_t c);
      case (c)
         COIN_1:  return VAL_1;
         COIN_5:  return VAL_5;
         COIN_10: return VAL_10;
         default: return VAL_50;
      endcase
   endfunction

endpackage

// File: rtl/dispense_ctrl_coin_select.sv
// rtl/dispense_ctrl_coin_select.sv - combinational pick of the largest available coin not above the amount
module coin_select
   import dispense_ctrl_pkg::*;
(
   input  logic [7:0] amount,
   input  logic [3:0] avail,
   output logic       valid,
   output coin_t      coin_type,
   output logic [7:0] value
);

   always_comb begin
      valid     = 1'b0;
      coin_type = COIN_1;
      if (avail[3] && amount >= VAL_50) begin
         valid     = 1'b1;
         coin_type = COIN_50;
      end else if (avail[2] && amount >= VAL_10) begin
         valid     = 1'b1;
         coin_type = COIN_10;
      end else if (avail[1] && amount >= VAL_5) begin
         valid     = 1'b1;
         coin_type = COIN_5;
      end else if (avail[0] && amount >= VAL_1) begin
         valid     = 1'b1;
         coin_type = COIN_1;
      end
      value = coin_value(coin_type);
   end

endmodule

// File: rtl/dispense_ctrl.sv
// rtl/dispense_ctrl.sv - ticket and change dispenser FSM; COIN_INVENTORY_EN enables finite coin stock
module dispense_ctrl
   import dispense_ctrl_pkg::*;
#(
   parameter logic [7:0] INIT_COIN_CNT = 8'd20
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] numOfTicket,
   input  logic [7:0] change,
   input  logic       ready,
   output logic       busy,
   output logic       ticketOut,
   output logic       coinOut,
   output logic [1:0] coinType,
   output logic [2:0] ticketsLeft,
   output logic [7:0] changeLeft,
   output logic       done,
   output logic       error
);

   state_t     state, state_d;
   logic [2:0] tickets_d;
   logic [7:0] change_d;
   logic       ticket_d, coin_d, done_d, busy_d, error_d;
   coin_t      type_d;
   logic [3:0] avail;
   logic       sel_valid;
   coin_t      sel_type;
   logic [7:0] sel_value;

   coin_select u_coin_select (
      .amount    (changeLeft),
      .avail     (avail),
      .valid     (sel_valid),
      .coin_type (sel_type),
      .value     (sel_value)
   );

`ifdef COIN_INVENTORY_EN
   logic [7:0] coin_cnt [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         avail[i] = (coin_cnt[i] != 8'd0);
      end
   end

   // Stock reloads only on reset; a new sale keeps whatever is left.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            coin_cnt[i] <= INIT_COIN_CNT;
         end
      end else if (coin_d) begin
         coin_cnt[type_d] <= coin_cnt[type_d] - 8'd1;
      end
   end
`else
   logic unused_init;
   assign avail       = 4'b1111;
   assign unused_init = ^INIT_COIN_CNT;
`endif

   always_comb begin
      state_d   = state;
      tickets_d = ticketsLeft;
      change_d  = changeLeft;
      ticket_d  = 1'b0;
      coin_d    = 1'b0;
      done_d    = 1'b0;
      type_d    = coin_t'(coinType);
      error_d   = error;
      case (state)
         IDLE: begin
            if (start) begin
               tickets_d = numOfTicket;
               change_d  = change;
               error_d   = 1'b0;
               if (numOfTicket != 3'd0) state_d = TICKET;
               else if (change != 8'd0) state_d = CHANGE;
               else                     state_d = DONE;
            end
         end
         TICKET: begin
            if (ready) begin
               ticket_d  = 1'b1;
               tickets_d = ticketsLeft - 3'd1;
               if (ticketsLeft == 3'd1) begin
                  state_d = (changeLeft != 8'd0) ? CHANGE : DONE;
               end
            end
         end
         CHANGE: begin
            // Out of usable coins: give up without waiting for ready, leaving the unpaid amount visible.
            if (!sel_valid) begin
`ifdef COIN_INVENTORY_EN
               error_d = 1'b1;
`endif
               state_d = DONE;
            end else if (ready) begin
               coin_d   = 1'b1;
               type_d   = sel_type;
               change_d = changeLeft - sel_value;
               if (changeLeft == sel_value) state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         ticketOut   <= 1'b0;
         coinOut     <= 1'b0;
         coinType    <= 2'b00;
         ticketsLeft <= 3'd0;
         changeLeft  <= 8'd0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= state_d;
         busy        <= busy_d;
         ticketOut   <= ticket_d;
         coinOut     <= coin_d;
         coinType    <= type_d;
         ticketsLeft <= tickets_d;
         changeLeft  <= change_d;
         done        <= done_d;
         error       <= error_d;
      end
   end

endmodule

// File: tb/tb_dispense_ctrl.sv
// tb/tb_dispense_ctrl.sv - randomized and directed self-checking bench for dispense_ctrl
module tb_dispense_ctrl;

`ifdef COIN_INVENTORY_EN
   localparam logic [7:0] INIT = 8'd1;
   localparam bit         INV  = 1'b1;
`else
   localparam logic [7:0] INIT = 8'd20;
   localparam bit         INV  = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       ready = 1'b0;
   logic [2:0] numOfTicket = 3'd0;
   logic [7:0] change = 8'd0;
   logic       busy, ticketOut, coinOut, done, error;
   logic [1:0] coinType;
   logic [2:0] ticketsLeft;
   logic [7:0] changeLeft;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dispense_ctrl #(.INIT_COIN_CNT(INIT)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .numOfTicket (numOfTicket),
      .change      (change),
      .ready       (ready),
      .busy        (busy),
      .ticketOut   (ticketOut),
      .coinOut     (coinOut),
      .coinType    (coinType),
      .ticketsLeft (ticketsLeft),
      .changeLeft  (changeLeft),
      .done        (done),
      .error       (error)
   );

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void chk_s(input string nm, input string act, input string exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got \"%s\" expected \"%s\" at %0t", nm, act, exp, $time);
      end
   endfunction

   // Sale model: a sale is a queue of items (10 = ticket, 0..3 = coin type, 20 = unpayable).
   int q[$];
   int cnt[4];
   int val[4] = '{1, 5, 10, 50};
   bit m_active, m_tick, m_coin, m_done, m_err;
   int m_tl, m_cl, m_type;

   always @(posedge clk) begin : model
      int rem;
      int d;
      int it;
      if (reset) begin
         q.delete();
         m_active = 0; m_tick = 0; m_coin = 0; m_done = 0; m_err = 0;
         m_tl = 0; m_cl = 0; m_type = 0;
         for (int i = 0; i < 4; i++) cnt[i] = INIT;
      end else begin
         m_tick = 0; m_coin = 0; m_done = 0;
         if (!m_active) begin
            if (start) begin
               m_active = 1; m_err = 0;
               m_tl = numOfTicket; m_cl = change;
               q.delete();
               for (int i = 0; i < numOfTicket; i++) q.push_back(10);
               rem = change;
               while (rem > 0) begin
                  d = -1;
                  for (int k = 3; k >= 0; k--)
                     if (d < 0 && val[k] <= rem && (!INV || cnt[k] > 0)) d = k;
                  if (d < 0) begin
                     q.push_back(20);
                     break;
                  end
                  q.push_back(d);
                  rem -= val[d];
                  cnt[d]--;
               end
            end
         end else if (q.size() == 0) begin
            m_done = 1;
            m_active = 0;
         end else if (q[0] == 20) begin
            m_err = 1;
            void'(q.pop_front());
         end else if (ready) begin
            it = q.pop_front();
            if (it == 10) begin
               m_tick = 1;
               m_tl--;
            end else begin
               m_coin = 1;
               m_type = it;
               m_cl -= val[it];
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", busy, m_active);
      chk("ticketOut", ticketOut, m_tick);
      chk("coinOut", coinOut, m_coin);
      chk("coinType", coinType, m_type);
      chk("ticketsLeft", ticketsLeft, m_tl);
      chk("changeLeft", changeLeft, m_cl);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("pulse_exclusive", ticketOut & coinOut, 0);
   end

   // Runs one sale and returns one character per cycle: T ticket, 0..3 coin type, D done, - idle.
   task automatic sale(input int n, input int c, input int drop_from, input int drop_len,
                       input int busy_start_at, output string seq);
      bit got_done;
      got_done = 0;
      seq = "";
      @(negedge clk);
      start = 1; numOfTicket = n[2:0]; change = c[7:0]; ready = 1;
      @(negedge clk);
      start = 0;
      for (int i = 1; i <= 40 && !got_done; i++) begin
         ready = !(i >= drop_from && i < drop_from + drop_len);
         if (i == busy_start_at) begin
            start = 1; numOfTicket = 3'd7; change = 8'd200;
         end
         @(negedge clk);
         start = 0;
         if (ticketOut)    seq = {seq, "T"};
         else if (coinOut) seq = {seq, $sformatf("%0d", coinType)};
         else if (done)    seq = {seq, "D"};
         else              seq = {seq, "-"};
         if (done) got_done = 1;
      end
      if (!got_done) seq = {seq, "?timeout"};
      ready = 1;
   endtask

   initial begin
      string s;
      reset = 1;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ticketsLeft", ticketsLeft, 0);
      chk("rst_changeLeft", changeLeft, 0);
      chk("rst_error", error, 0);
      reset = 0;

`ifdef COIN_INVENTORY_EN
      sale(0, 20, 0, 0, 0, s);   chk_s("inv_short_change", s, "210-D");
      chk("inv_error_set", error, 1);
      chk("inv_unpaid", changeLeft, 4);
      sale(0, 0, 0, 0, 0, s);    chk_s("inv_next_sale", s, "D");
      chk("inv_error_cleared", error, 0);
`else
      sale(2, 20, 0, 0, 0, s);   chk_s("sale_2_20", s, "TT22D");
      sale(5, 5, 0, 0, 0, s);    chk_s("sale_5_5", s, "TTTTT1D");
      sale(0, 68, 0, 0, 0, s);   chk_s("sale_0_68", s, "321000D");
      sale(0, 0, 0, 0, 0, s);    chk_s("sale_0_0", s, "D");
      sale(0, 68, 2, 3, 0, s);   chk_s("ready_drop", s, "3---21000D");
      sale(3, 0, 0, 0, 1, s);    chk_s("start_while_busy", s, "TTTD");
      chk("max_change_after", changeLeft, 0);
`endif

      // Reset in the middle of a ticket run discards the sale.
      @(negedge clk);
      start = 1; numOfTicket = 3'd5; change = 8'd5; ready = 1;
      @(negedge clk);
      start = 0;
      repeat (2) @(negedge clk);
      chk("mid_ticket_busy", busy, 1);
      reset = 1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_ticketOut", ticketOut, 0);
      chk("midrst_ticketsLeft", ticketsLeft, 0);
      chk("midrst_changeLeft", changeLeft, 0);
      reset = 0;
      repeat (3) @(negedge clk);
      chk("not_resumed", busy, 0);

      for (int cyc = 0; cyc < 4000; cyc++) begin
         reset       = ($urandom_range(0, 149) == 0);
         start       = ($urandom_range(0, 4) == 0);
         numOfTicket = 3'($urandom_range(0, 7));
         change      = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 20));
         ready       = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      reset = 0; start = 0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dispense_ctrl.md
DISPENSE_CTRL -- requirements
Module: dispense_ctrl

Interface
REQ-001 Parameter: INIT_COIN_CNT, default 8'd20, reset value of each per-denomination coin counter (used only with COIN_INVENTORY_EN).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to dispense the sale latched from the upstream ticket-sale stage.
REQ-005 numOfTicket  input  3  tickets to issue, 0..7, sampled with start.
REQ-006 change  input  8  change owed in currency units, 0..255, sampled with start.
REQ-007 ready  input  1  mechanism can accept one item this cycle.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 ticketOut  output  1  one-cycle pulse, one ticket issued.
REQ-010 coinOut  output  1  one-cycle pulse, one coin issued.
REQ-011 coinType  output  2  denomination of the current coinOut: 00=1, 01=5, 10=10, 11=50.
REQ-012 ticketsLeft  output  3  tickets still to issue.
REQ-013 changeLeft  output  8  change still to pay.
REQ-014 done  output  1  one-cycle pulse, sale complete.
REQ-015 error  output  1  sticky flag, change could not be fully paid (COIN_INVENTORY_EN only; tied 0 otherwise).

Function
REQ-016 FSM states: IDLE, TICKET, CHANGE, DONE. All outputs are registered.
REQ-017 In IDLE, start=1 latches numOfTicket into ticketsLeft and change into changeLeft. The next state is TICKET if numOfTicket>0, else CHANGE if change>0, else DONE.
REQ-018 start is ignored in every state except IDLE.
REQ-019 In TICKET, each edge with ready=1 pulses ticketOut and decrements ticketsLeft. When ticketsLeft reaches 0, the next state is CHANGE if changeLeft>0, else DONE.
REQ-020 In CHANGE, each edge with ready=1 pulses coinOut. coinType is the largest denomination <= changeLeft, and changeLeft is reduced by that coin's value. When changeLeft reaches 0, the next state is DONE.
REQ-021 If ready=0 in TICKET or CHANGE: no pulse, counters held, state held.
REQ-022 DONE pulses done for exactly one cycle and returns to IDLE.
REQ-023 Latency with ready held high: start sampled at edge 0; N tickets and M coins issue on edges 1..N+M; done is high after edge N+M+1.
REQ-024 ticketOut and coinOut are never high in the same cycle.
REQ-025 Pulses are high only in the cycle after the edge that issues them.
REQ-026 The arithmetic is unsigned 8-bit, and a subtraction never exceeds changeLeft, so changeLeft never underflows.

Reset
REQ-027 reset=1 at an edge forces IDLE and sets busy, ticketOut, coinOut, done and error to 0, coinType to 00, and ticketsLeft and changeLeft to 0, in any state including mid-sale.
REQ-028 The aborted sale is discarded and not resumed.
REQ-029 Coin counters reload to INIT_COIN_CNT on reset only, not on start.

Configuration
REQ-030 Macro COIN_INVENTORY_EN defined: four 8-bit coin counters are kept.
REQ-031 With COIN_INVENTORY_EN, selection picks the largest denomination <= changeLeft whose counter is >0, and each coin issued decrements its counter.
REQ-032 With COIN_INVENTORY_EN, if changeLeft>0 and no denomination qualifies, error is set, the FSM goes to DONE, and changeLeft holds the unpaid amount.
REQ-033 With COIN_INVENTORY_EN, error clears on reset or the next accepted start.
REQ-034 Macro undefined: supply is unlimited, no counters exist, and error is constant 0.

Structure
REQ-035 The shared package holds the state encoding, the coinType encodings, and the coin value constants 1/5/10/50.
REQ-036 Sub-module coin_select is combinational. It takes changeLeft and the availability mask and returns coinType and the coin value.

Verification
REQ-037 numOfTicket=2, change=20, ready=1 gives ticketOut after edges 1–2, then coinOut type 10 twice after edges 3–4, then done after edge 5.
REQ-038 numOfTicket=5, change=5 gives 5 ticketOut pulses, then one coinOut with coinType=01, then done after edge 7.
REQ-039 numOfTicket=0, change=68 gives coins 50, 10, 5, 1, 1, 1 on edges 1–6 and done after edge 7; numOfTicket=0, change=0 gives done after edge 1.
REQ-040 Dropping ready for 3 cycles mid-CHANGE produces no pulses and holds changeLeft and state; dispensing resumes on the first edge with ready=1.
REQ-041 reset asserted during TICKET gives IDLE and all outputs 0 on the next edge; a start pulse during busy is ignored.
REQ-042 With COIN_INVENTORY_EN and INIT_COIN_CNT=1, change=20 gives coins 10, 5, 1, then error=1 and done with changeLeft=4; the next start clears error.
